wb_regfile_sb: RTL and testbench
================================

// Module: wb_regfile_sb
// PURPOSE
//  Writeback-side consumer of the EX-stage destination select (rd/rt or 5'd31 on jal).
//  Holds the 32x32 GPR array, a per-register pending-write scoreboard and a registered write port.
//  Sits between the MEM/WB pipeline register and the ID-stage operand read / hazard logic.
//  Drives stall to ID while a source operand has an outstanding, unretired writer.
// PARAMETERS
//  DW      32  data width of each GPR
//  PEND_W  2   width of per-register in-flight counter (max 2**PEND_W-1 writers)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  iss_valid    in   1   EX accepted an instruction that will write iss_dest
//  iss_jal      in   1   issued instr is jal; destination forced to 5'd31
//  iss_dest     in   5   destination index when iss_jal=0
//  iss_ready    out  1   0 = target counter saturated; EX must hold
//  wb_valid     in   1   WB retires one write this cycle
//  wb_jal       in   1   retiring instr is jal; destination forced to 5'd31
//  wb_dest      in   5   destination index when wb_jal=0
//  wb_data      in   DW  write data (PC+8 for jal)
//  rs_addr      in   5   ID read port A index
//  rt_addr      in   5   ID read port B index
//  rs_data      out  DW  read port A data
//  rt_data      out  DW  read port B data
//  stall        out  1   1 = rs or rt has a pending writer not yet visible
// BEHAVIOUR
//  - Reset (async, rst_n=0): all GPRs <= 0, all pending counters <= 0, write stage
//    valid <= 0; hence stall=0, iss_ready=1, rs_data=rt_data=0 immediately.
//  - Effective dest: eff = jal ? 5'd31 : dest (both iss and wb sides).
//  - Issue: iss_valid && iss_ready && eff!=0 -> pend[eff] += 1 at next edge.
//    eff==0 never counted. iss_ready = (pend[eff_iss] != max) || eff_iss==0.
//  - Write stage: wb_valid captured into wv/wa/wd at edge N; array[wa] <= wd at edge N+1
//    (one-cycle write latency); pend[wa] -= 1 at edge N+1 with the array update.
//  - wb_valid with eff==0 or pend[eff]==0: data dropped, counters untouched (no underflow).
//  - Same-cycle inc and dec on one register: counter unchanged.
//  - r0: reads always 0, never written, pend[0] constant 0.
//  - Reads combinational from array (bypass per CONFIGURATION).
//  - stall = (rs_addr!=0 && pend[rs_addr]!=0 && !byp_rs) |
//            (rt_addr!=0 && pend[rt_addr]!=0 && !byp_rt); byp_* = 0 without macro.
//  - rst_n asserted mid-operation: in-flight write in write stage discarded.
// CONFIGURATION
//  WB_BYPASS_EN defined: if wv && wa==rs_addr (rt_addr) && wa!=0, rs_data (rt_data) = wd
//    and byp_rs (byp_rt)=1 when pend[wa]==1, removing that stall cycle.
//  WB_BYPASS_EN undefined: reads see array only; consumer stalls until array update edge.
// TESTING
//  reset: rst_n=0 mid-write of r5 -> rs_data(r5)=0, stall=0, iss_ready=1 after release.
//  jal link: iss_jal=1, later wb_jal=1 wb_data=32'h0040_0008 -> r31 reads 32'h0040_0008,
//    stall on rs_addr=31 high from issue until update (one cycle earlier with WB_BYPASS_EN).
//  r0: iss_dest=0, wb_dest=0 wb_data=32'hFFFF_FFFF -> rs_data(r0)=0, stall never asserts.
//  saturation: 3 issues to r7 without writeback -> iss_ready=0 for r7, 1 for r8; one wb to r7
//    -> iss_ready returns 1 the cycle after the array update.
//  simultaneous: issue r9 and retire r9 same cycle with pend[r9]=1 -> pend stays 1, stall stays 1.
//  spurious wb: wb_valid to r12 with pend=0 -> counters unchanged, no underflow, stall=0.

Source files
------------

// File: rtl/wb_regfile_sb.sv
// Writeback-side GPR file with per-register pending-write scoreboard and registered write port.
// Optional WB_BYPASS_EN: forwards the write-stage data to the read ports and hides the last stall cycle.
module wb_regfile_sb #(
  parameter int DW     = 32,
  parameter int PEND_W = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iss_valid,
  input  logic          iss_jal,
  input  logic [4:0]    iss_dest,
  output logic          iss_ready,
  input  logic          wb_valid,
  input  logic          wb_jal,
  input  logic [4:0]    wb_dest,
  input  logic [DW-1:0] wb_data,
  input  logic [4:0]    rs_addr,
  input  logic [4:0]    rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic          stall
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [DW-1:0]     regs [32];
  logic [PEND_W-1:0] pend [32];

  logic              wv;
  logic [4:0]        wa;
  logic [DW-1:0]     wd;

  logic [4:0]        eff_iss;
  logic [4:0]        eff_wb;
  logic              iss_inc;
  logic              wb_take;
  logic              wr_dec;
  logic              byp_rs;
  logic              byp_rt;

  always_comb begin
    eff_iss   = iss_jal ? 5'd31 : iss_dest;
    eff_wb    = wb_jal  ? 5'd31 : wb_dest;
    iss_ready = (eff_iss == 5'd0) || (pend[eff_iss] != PEND_MAX);
    iss_inc   = iss_valid && iss_ready && (eff_iss != 5'd0);
    // Writes with no outstanding issue are dropped at capture so the counter cannot underflow.
    wb_take   = wb_valid && (eff_wb != 5'd0) && (pend[eff_wb] != '0);
    wr_dec    = wv && (pend[wa] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
      wv <= 1'b0;
      wa <= '0;
      wd <= '0;
    end else begin
      wv <= wb_take;
      wa <= eff_wb;
      wd <= wb_data;
      if (wv && (wa != 5'd0))
        regs[wa] <= wd;
      // r0 is skipped so its counter stays zero; a coincident inc and dec cancel.
      for (int unsigned i = 1; i < 32; i++) begin
        if (iss_inc && (eff_iss == 5'(i)) && !(wr_dec && (wa == 5'(i))))
          pend[i] <= pend[i] + PEND_ONE;
        else if (wr_dec && (wa == 5'(i)) && !(iss_inc && (eff_iss == 5'(i))))
          pend[i] <= pend[i] - PEND_ONE;
      end
    end
  end

  always_comb begin
    rs_data = (rs_addr == 5'd0) ? '0 : regs[rs_addr];
    rt_data = (rt_addr == 5'd0) ? '0 : regs[rt_addr];
    byp_rs  = 1'b0;
    byp_rt  = 1'b0;
`ifdef WB_BYPASS_EN
    if (wv && (wa != 5'd0) && (wa == rs_addr)) begin
      rs_data = wd;
      byp_rs  = (pend[wa] == PEND_ONE);
    end
    if (wv && (wa != 5'd0) && (wa == rt_addr)) begin
      rt_data = wd;
      byp_rt  = (pend[wa] == PEND_ONE);
    end
`endif
    stall = ((rs_addr != 5'd0) && (pend[rs_addr] != '0) && !byp_rs) ||
            ((rt_addr != 5'd0) && (pend[rt_addr] != '0) && !byp_rt);
  end

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Scoreboard bench for wb_regfile_sb: stimulus pushes hand-computed expectations, a negedge monitor pops and checks.
module tb_wb_regfile_sb;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid, iss_jal, iss_ready;
  logic [4:0]  iss_dest;
  logic        wb_valid, wb_jal;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic        stall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic        st;
    logic        rdy;
  } exp_t;

  exp_t sb[$];

  wb_regfile_sb #(.DW(32), .PEND_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_jal(iss_jal), .iss_dest(iss_dest), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_jal(wb_jal), .wb_dest(wb_dest), .wb_data(wb_data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .stall(stall)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks += 4;
      if (rs_data !== e.rsd) begin
        errors++;
        $display("FAIL %s rs_data got %h want %h", e.name, rs_data, e.rsd);
      end
      if (rt_data !== e.rtd) begin
        errors++;
        $display("FAIL %s rt_data got %h want %h", e.name, rt_data, e.rtd);
      end
      if (stall !== e.st) begin
        errors++;
        $display("FAIL %s stall got %b want %b", e.name, stall, e.st);
      end
      if (iss_ready !== e.rdy) begin
        errors++;
        $display("FAIL %s iss_ready got %b want %b", e.name, iss_ready, e.rdy);
      end
    end
  end

  task automatic cyc(input logic iv, input logic ij, input logic [4:0] id,
                     input logic wvv, input logic wj, input logic [4:0] wdst,
                     input logic [31:0] wdat, input logic [4:0] rs, input logic [4:0] rt);
    @(posedge clk);
    #1;
    iss_valid = iv;  iss_jal = ij;  iss_dest = id;
    wb_valid  = wvv; wb_jal  = wj;  wb_dest  = wdst; wb_data = wdat;
    rs_addr   = rs;  rt_addr = rt;
  endtask

  task automatic expect_out(input string n, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic r);
    exp_t e;
    e.name = n; e.rsd = a; e.rtd = b; e.st = s; e.rdy = r;
    sb.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    iss_valid = 0; iss_jal = 0; iss_dest = 0;
    wb_valid = 0; wb_jal = 0; wb_dest = 0; wb_data = 0;
    rs_addr = 0; rt_addr = 0;
    repeat (2) @(posedge clk);

    // reset, with a write to r5 in flight when reset hits again
    cyc(0,0,5, 0,0,0,0, 5,0);               expect_out("rst_hold", 0, 0, 0, 1);
    cyc(0,0,5, 0,0,0,0, 5,0); rst_n = 1'b1; expect_out("rst_rel", 0, 0, 0, 1);
    cyc(1,0,5, 0,0,0,0, 5,0);               expect_out("r5_issue", 0, 0, 0, 1);
    cyc(0,0,5, 0,0,0,0, 5,0);               expect_out("r5_pend", 0, 0, 1, 1);
    cyc(0,0,5, 1,0,5,32'h55, 5,0);          expect_out("r5_wb", 0, 0, 1, 1);
    cyc(0,0,5, 0,0,0,0, 5,0); rst_n = 1'b0; expect_out("r5_rst", 0, 0, 0, 1);
    cyc(0,0,5, 0,0,0,0, 5,0); rst_n = 1'b1; expect_out("r5_relax", 0, 0, 0, 1);
    cyc(0,0,5, 0,0,0,0, 5,0);               expect_out("r5_discard", 0, 0, 0, 1);

    // jal link into r31 (dest fields deliberately non-31)
    cyc(1,1,3, 0,0,0,0, 31,31);             expect_out("jal_issue", 0, 0, 0, 1);
    cyc(0,0,0, 0,0,0,0, 31,31);             expect_out("jal_pend", 0, 0, 1, 1);
    cyc(0,0,0, 1,1,4,32'h0040_0008, 31,31); expect_out("jal_wb", 0, 0, 1, 1);
    cyc(0,0,0, 0,0,0,0, 31,31);
    expect_out("jal_wstage", BYP ? 32'h0040_0008 : 32'h0, BYP ? 32'h0040_0008 : 32'h0, !BYP, 1);
    cyc(0,0,0, 0,0,0,0, 31,31);             expect_out("jal_done", 32'h0040_0008, 32'h0040_0008, 0, 1);

    // r0 is never counted nor written
    cyc(1,0,0, 1,0,0,32'hFFFF_FFFF, 0,0);   expect_out("r0_a", 0, 0, 0, 1);
    cyc(0,0,0, 0,0,0,0, 0,0);               expect_out("r0_b", 0, 0, 0, 1);
    cyc(0,0,0, 0,0,0,0, 0,0);               expect_out("r0_c", 0, 0, 0, 1);

    // saturation of r7 counter at 3
    cyc(1,0,7, 0,0,0,0, 7,8);               expect_out("sat1", 0, 0, 0, 1);
    cyc(1,0,7, 0,0,0,0, 7,8);               expect_out("sat2", 0, 0, 1, 1);
    cyc(1,0,7, 0,0,0,0, 7,8);               expect_out("sat3", 0, 0, 1, 1);
    cyc(0,0,7, 0,0,0,0, 7,8);               expect_out("sat_full", 0, 0, 1, 0);
    cyc(0,0,8, 0,0,0,0, 7,8);               expect_out("sat_other", 0, 0, 1, 1);
    cyc(1,0,7, 1,0,7,32'h77, 7,8);          expect_out("sat_blocked", 0, 0, 1, 0);
    cyc(0,0,7, 0,0,0,0, 8,8);               expect_out("sat_wstage", 0, 0, 0, 0);
    cyc(0,0,7, 0,0,0,0, 7,8);               expect_out("sat_freed", 32'h77, 0, 1, 1);

    // r9: issue coincides with the write-stage decrement
    cyc(1,0,9, 0,0,0,0, 9,0);               expect_out("r9_issue", 0, 0, 0, 1);
    cyc(0,0,9, 1,0,9,32'h99, 9,0);          expect_out("r9_wb", 0, 0, 1, 1);
    cyc(1,0,9, 0,0,0,0, 9,0);               expect_out("r9_sim", BYP ? 32'h99 : 32'h0, 0, !BYP, 1);
    cyc(0,0,9, 0,0,0,0, 9,0);               expect_out("r9_hold", 32'h99, 0, 1, 1);
    cyc(0,0,9, 1,0,9,32'h9A, 9,0);          expect_out("r9_wb2", 32'h99, 0, 1, 1);
    cyc(0,0,9, 0,0,0,0, 9,0);               expect_out("r9_wstage2", BYP ? 32'h9A : 32'h99, 0, !BYP, 1);
    cyc(0,0,9, 0,0,0,0, 9,0);               expect_out("r9_done", 32'h9A, 0, 0, 1);

    // spurious writeback to r12 with nothing pending
    cyc(0,0,12, 1,0,12,32'hC, 12,9);        expect_out("sp_wb", 0, 32'h9A, 0, 1);
    cyc(0,0,12, 0,0,0,0, 12,9);             expect_out("sp_after", 0, 32'h9A, 0, 1);
    cyc(0,0,12, 0,0,0,0, 12,9);             expect_out("sp_after2", 0, 32'h9A, 0, 1);
    cyc(1,0,12, 0,0,0,0, 12,9);             expect_out("sp_issue", 0, 32'h9A, 0, 1);
    cyc(0,0,12, 1,0,12,32'h12C, 12,9);      expect_out("sp_pend", 0, 32'h9A, 1, 1);
    cyc(0,0,12, 0,0,0,0, 12,9);             expect_out("sp_wstage", BYP ? 32'h12C : 32'h0, 32'h9A, !BYP, 1);
    cyc(0,0,12, 0,0,0,0, 12,9);             expect_out("sp_done", 32'h12C, 32'h9A, 0, 1);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
